// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory port: RV32I width codes and responder FSM states.
// The CPU MEM stage imports this package as well.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering for the data-memory responder: store byte enables and data
// replication, load lane extraction with sign/zero extension, and alignment/funct3 error flag.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic        we,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext,
  output logic        err
);

  logic [31:0] rword_shift;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign rword_shift = rword >> {addr_lo, 3'b000};
  assign byte_sel    = rword_shift[7:0];
  assign half_sel    = addr_lo[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    be         = 4'b0000;
    wdata_lane = '0;
    rdata_ext  = '0;
    err        = 1'b0;
    case (funct3)
      F3_B: begin
        be         = 4'b0001 << addr_lo;
        wdata_lane = {4{wdata[7:0]}};
        rdata_ext  = {{24{byte_sel[7]}}, byte_sel};
      end
      F3_BU: begin
        // unsigned widths exist only for loads
        err       = we;
        rdata_ext = {24'd0, byte_sel};
      end
      F3_H: begin
        err        = addr_lo[0];
        be         = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_lane = {2{wdata[15:0]}};
        rdata_ext  = {{16{half_sel[15]}}, half_sel};
      end
      F3_HU: begin
        err       = we | addr_lo[0];
        rdata_ext = {16'd0, half_sel};
      end
      F3_W: begin
        err        = (addr_lo != 2'b00);
        be         = 4'b1111;
        wdata_lane = wdata;
        rdata_ext  = rword;
      end
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: slave end of the CPU load/store port with programmable wait states,
// byte/half/word stores, extended loads and an error response path.
//
// state | meaning
// IDLE  | req_ready high, waiting for a request
// WAIT  | request captured, counting down wait states; access on terminal count
// RESP  | response registered, rsp_valid high until rsp_ready
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int    ADDR_WIDTH  = 12,
  parameter int    WAIT_CYCLES = 1,
  parameter string INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int DEPTH = 2 ** (ADDR_WIDTH - 2);

  dmem_state_t state, state_nxt;
  logic [3:0]  wait_cnt;
  logic        cap_we;
  logic [31:0] cap_addr;
  logic [2:0]  cap_funct3;
  logic [31:0] cap_wdata;

  logic [31:0] mem [DEPTH];

  logic                  accept;
  logic                  access;
  logic                  range_err;
  logic                  err_any;
  logic                  wr_en;
  logic [ADDR_WIDTH-3:0] word_idx;
  logic [3:0]            be;
  logic [31:0]           wdata_lane;
  logic [31:0]           rdata_ext;
  logic                  align_err;

  assign req_ready = (state == IDLE) && !rst;
  assign rsp_valid = (state == RESP);
  assign accept    = req_valid && req_ready;
  assign access    = (state == WAIT) && (wait_cnt == 4'd0);
  assign range_err = |cap_addr[31:ADDR_WIDTH];
  assign err_any   = range_err | align_err;
  assign wr_en     = access && cap_we && !err_any;
  assign word_idx  = cap_addr[ADDR_WIDTH-1:2];

  dmem_lane_align u_lane_align (
    .we         (cap_we),
    .addr_lo    (cap_addr[1:0]),
    .funct3     (cap_funct3),
    .wdata      (cap_wdata),
    .rword      (mem[word_idx]),
    .be         (be),
    .wdata_lane (wdata_lane),
    .rdata_ext  (rdata_ext),
    .err        (align_err)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = WAIT;
      WAIT:    if (wait_cnt == 4'd0) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt   <= 4'd0;
      cap_we     <= 1'b0;
      cap_addr   <= '0;
      cap_funct3 <= '0;
      cap_wdata  <= '0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      if (accept) begin
        wait_cnt   <= 4'(WAIT_CYCLES);
        cap_we     <= req_we;
        cap_addr   <= req_addr;
        cap_funct3 <= req_funct3;
        cap_wdata  <= req_wdata;
      end else if ((state == WAIT) && (wait_cnt != 4'd0)) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      if (access) begin
        rsp_rdata <= (cap_we || err_any) ? 32'd0 : rdata_ext;
        rsp_err   <= err_any;
      end
    end
  end

  // storage is deliberately outside the reset domain
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[word_idx][8*i +: 8] <= wdata_lane[8*i +: 8];
      end
    end
  end

endmodule
